// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: state encoding, error codes and default header bytes shared by
// the frame parser and its payload buffer.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_CHK = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_OVR = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

  // A length byte is usable when it is non-zero and fits the payload buffer.
  function automatic logic len_ok(input logic [7:0] len, input int unsigned max_len);
    return (len != 8'd0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: DEPTH x 8 simple dual-port payload RAM.
// Synchronous write; registered read with one cycle of latency.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // write port; contents need no reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port, cleared so the output starts from a known value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles HDR0 HDR1 LEN payload CHK frames from uart_rx byte
// strobes, buffers the payload and streams it downstream (valid/ready) only once the
// checksum (LEN + payload, mod 256) matches.
// Build macro UART_FRAME_TIMEOUT_EN adds an inter-byte gap timeout while parsing.
//
// state      | meaning
// ST_IDLE    | hunting for HDR0
// ST_HDR     | HDR0 seen, expecting HDR1
// ST_LEN     | expecting the length byte
// ST_PAYLOAD | storing payload bytes into the buffer
// ST_CHK     | expecting the checksum byte
// ST_DRAIN   | streaming the buffered payload downstream
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] HDR0         = HDR0_DEF,
  parameter logic [7:0] HDR1         = HDR1_DEF,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       pl_valid,
  output logic [7:0] pl_data,
  output logic       pl_last,
  input  logic       pl_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t        state_q, state_d;
  logic [7:0]    len_q, sum_q;
  logic [AW-1:0] idx_q, rd_idx_q, rd_next;
  logic [7:0]    buf_rdata;
  logic          len_load, pay_wr, ok_set, err_set;
  logic          valid_set, valid_clr, rd_adv;
  logic          hs, last_rd, tmo_hit;
  logic [1:0]    err_code_d;

  assign hs      = pl_valid & pl_ready;
  assign last_rd = (8'(rd_idx_q) == len_q - 8'd1);
  assign pl_last = pl_valid & last_rd;
  // buffer output is only meaningful while a byte is being presented
  assign pl_data = pl_valid ? buf_rdata : 8'd0;

  // read address runs one ahead on a handshake so the next byte is ready next cycle;
  // it holds on a stall so the presented byte stays put
  assign rd_next = rd_adv ? (rd_idx_q + AW'(1)) : rd_idx_q;

  // next-state and per-cycle control strobes
  always_comb begin
    state_d    = state_q;
    len_load   = 1'b0;
    pay_wr     = 1'b0;
    ok_set     = 1'b0;
    err_set    = 1'b0;
    err_code_d = ERR_CHK;
    valid_set  = 1'b0;
    valid_clr  = 1'b0;
    rd_adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_done && rx_data == HDR0) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (rx_done) begin
          if (rx_data == HDR1)      state_d = ST_LEN;
          else if (rx_data == HDR0) state_d = ST_HDR;
          else                      state_d = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (rx_done) begin
          if (len_ok(rx_data, MAX_LEN)) begin
            len_load = 1'b1;
            state_d  = ST_PAYLOAD;
          end else begin
            err_set    = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_done) begin
          pay_wr = 1'b1;
          if (8'(idx_q) == len_q - 8'd1) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_done) begin
          if (rx_data == sum_q) begin
            ok_set  = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            err_set    = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        // a byte arriving now has nowhere to go; report it but keep draining
        if (rx_done) begin
          err_set    = 1'b1;
          err_code_d = ERR_OVR;
        end
        // first drain cycle: the read of byte 0 is in flight, present it next cycle
        if (!pl_valid) valid_set = 1'b1;
        if (hs) begin
          if (last_rd) begin
            valid_clr = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            rd_adv = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // tmo_hit only fires in parsing states on cycles without rx_done
    if (tmo_hit) begin
      state_d    = ST_IDLE;
      err_set    = 1'b1;
      err_code_d = ERR_TMO;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // length, checksum and buffer index bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      rd_idx_q <= '0;
    end else begin
      if (len_load) begin
        len_q    <= rx_data;
        sum_q    <= rx_data;
        idx_q    <= '0;
        rd_idx_q <= '0;
      end
      if (pay_wr) begin
        sum_q <= sum_q + rx_data;
        idx_q <= idx_q + AW'(1);
      end
      if (rd_adv) rd_idx_q <= rd_next;
    end
  end

  // registered status pulses and stream valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_CHK;
      pl_valid  <= 1'b0;
    end else begin
      frame_ok  <= ok_set;
      frame_err <= err_set;
      if (err_set)        err_code <= err_code_d;
      if (valid_set)      pl_valid <= 1'b1;
      else if (valid_clr) pl_valid <= 1'b0;
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [TW-1:0] gap_cnt;
  logic          in_parse;

  assign in_parse = state_q inside {ST_HDR, ST_LEN, ST_PAYLOAD, ST_CHK};
  assign tmo_hit  = in_parse && !rx_done && (gap_cnt == '0);

  // gap down-counter: reloads on every byte and outside parsing, expires TIMEOUT_CLKS
  // cycles after the last byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      gap_cnt <= '0;
    else if (rx_done || !in_parse) gap_cnt <= TW'(TIMEOUT_CLKS - 1);
    else                          gap_cnt <= gap_cnt - TW'(1);
  end
`else
  // no timer in this build: never fires (TIMEOUT_CLKS is a positive count)
  assign tmo_hit = (TIMEOUT_CLKS < 0);
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (pay_wr),
    .waddr (idx_q),
    .wdata (rx_data),
    .raddr (rd_next),
    .rdata (buf_rdata)
  );

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: table-driven frame vectors plus hand-written drain,
// overrun, reset and gap sequences for uart_frame_parser.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_last;
  logic       pl_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .MAX_LEN      (MAX_LEN),
    .HDR0         (8'h55),
    .HDR1         (8'hAA),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .pl_valid  (pl_valid),
    .pl_data   (pl_data),
    .pl_last   (pl_last),
    .pl_ready  (pl_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  int         mon_ok, mon_err, hs_first, hs_last;
  logic [1:0] mon_code;
  logic [7:0] cap_d[$];
  logic       cap_l[$];

  task automatic mon_clear();
    mon_ok   = 0;
    mon_err  = 0;
    mon_code = 2'bxx;
    hs_first = -1;
    hs_last  = -1;
    cap_d.delete();
    cap_l.delete();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (frame_ok || frame_err) check("ok_err_exclusive", {31'd0, frame_ok & frame_err}, 32'd0);
      if (frame_ok) mon_ok++;
      if (frame_err) begin
        mon_err++;
        mon_code = err_code;
      end
      if (pl_valid && pl_ready) begin
        cap_d.push_back(pl_data);
        cap_l.push_back(pl_last);
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_bytes(input int n, input logic [63:0] w);
    for (int i = 0; i < n; i++) send_byte(w[8*(n-1-i) +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_for_valid(input int budget, input string name);
    int n = 0;
    while (pl_valid !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {31'd0, pl_valid}, 32'd1);
  endtask

  task automatic check_stream(input string name, input int n, input logic [63:0] w);
    check({name, "_count"}, cap_d.size(), n);
    for (int i = 0; i < n && i < cap_d.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), cap_d[i], w[8*(n-1-i) +: 8]);
      check($sformatf("%s_last%0d", name, i), cap_l[i], (i == n - 1) ? 1 : 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         f_off;
    int         f_n;
    int         p_off;
    int         p_n;
    int         n_ok;
    int         n_err;
    logic [1:0] code;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] pool[256];
  int         nv     = 0;
  int         pool_n = 0;

  task automatic vec_begin(input int ok, input int err, input logic [1:0] code);
    vecs[nv].f_off = pool_n;
    vecs[nv].f_n   = 0;
    vecs[nv].p_off = 0;
    vecs[nv].p_n   = 0;
    vecs[nv].n_ok  = ok;
    vecs[nv].n_err = err;
    vecs[nv].code  = code;
  endtask

  task automatic vec_frame(input int n, input logic [63:0] w);
    for (int i = 0; i < n; i++) begin
      pool[pool_n] = w[8*(n-1-i) +: 8];
      pool_n++;
    end
    vecs[nv].f_n += n;
  endtask

  task automatic vec_pl(input int n, input logic [63:0] w);
    if (vecs[nv].p_n == 0) vecs[nv].p_off = pool_n;
    for (int i = 0; i < n; i++) begin
      pool[pool_n] = w[8*(n-1-i) +: 8];
      pool_n++;
    end
    vecs[nv].p_n += n;
  endtask

  task automatic vec_end();
    nv++;
  endtask

  initial begin
    rst      = 1'b1;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    pl_ready = 1'b0;
    mon_clear();

    // good frame
    vec_begin(1, 0, 2'd0); vec_frame(7, 64'h55AA0311223369); vec_pl(3, 64'h112233); vec_end();
    // checksum error
    vec_begin(0, 1, 2'd0); vec_frame(7, 64'h55AA0311223368); vec_end();
    // LEN=0 and LEN=17 rejected, then a good one-byte frame
    vec_begin(1, 2, 2'd1); vec_frame(3, 64'h55AA00); vec_frame(3, 64'h55AA11);
    vec_frame(5, 64'h55AA017F80); vec_pl(1, 64'h7F); vec_end();
    // noise and repeated HDR0 before the header
    vec_begin(1, 0, 2'd0); vec_frame(8, 64'h005555AA02010205); vec_pl(2, 64'h0102); vec_end();
    // LEN == MAX_LEN
    vec_begin(1, 0, 2'd0); vec_frame(3, 64'h55AA10);
    vec_frame(8, 64'h0102030405060708); vec_frame(8, 64'h090A0B0C0D0E0F10); vec_frame(1, 64'h98);
    vec_pl(8, 64'h0102030405060708); vec_pl(8, 64'h090A0B0C0D0E0F10); vec_end();
    // broken header falls back silently, then a frame carrying a zero byte
    vec_begin(1, 0, 2'd0); vec_frame(6, 64'h5512AA01ABAC); vec_frame(5, 64'h55AA010001);
    vec_pl(1, 64'h00); vec_end();
    // header bytes inside the payload are data, not resync
    vec_begin(1, 0, 2'd0); vec_frame(6, 64'h55AA0255AA01); vec_pl(2, 64'h55AA); vec_end();
    // LEN=FF rejected
    vec_begin(0, 1, 2'd1); vec_frame(3, 64'h55AAFF); vec_end();

    // ---- reset state ----
    idle(3);
    check("rst_pl_valid",  {31'd0, pl_valid},  32'd0);
    check("rst_pl_data",   {24'd0, pl_data},   32'd0);
    check("rst_pl_last",   {31'd0, pl_last},   32'd0);
    check("rst_frame_ok",  {31'd0, frame_ok},  32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_err_code",  {30'd0, err_code},  32'd0);
    rst = 1'b0;
    idle(2);

    // ---- table vectors ----
    for (int v = 0; v < nv; v++) begin
      mon_clear();
      pl_ready = 1'b1;
      for (int i = 0; i < vecs[v].f_n; i++) send_byte(pool[vecs[v].f_off + i]);
      idle(40);
      check($sformatf("v%0d_ok_count", v), mon_ok, vecs[v].n_ok);
      check($sformatf("v%0d_err_count", v), mon_err, vecs[v].n_err);
      if (vecs[v].n_err > 0) check($sformatf("v%0d_err_code", v), {30'd0, mon_code}, {30'd0, vecs[v].code});
      check($sformatf("v%0d_pl_count", v), cap_d.size(), vecs[v].p_n);
      for (int i = 0; i < vecs[v].p_n && i < cap_d.size(); i++) begin
        check($sformatf("v%0d_data%0d", v, i), cap_d[i], pool[vecs[v].p_off + i]);
        check($sformatf("v%0d_last%0d", v, i), cap_l[i], (i == vecs[v].p_n - 1) ? 1 : 0);
      end
      if (vecs[v].p_n > 0) check($sformatf("v%0d_throughput", v), hs_last - hs_first, vecs[v].p_n - 1);
      check($sformatf("v%0d_idle_valid", v), {31'd0, pl_valid}, 32'd0);
    end

    // ---- stall mid-drain plus overrun ----
    mon_clear();
    pl_ready = 1'b0;
    send_bytes(8, 64'h55AA04A1B2C3D4EE);
    check("stall_ok_pulse", {31'd0, frame_ok}, 32'd1);
    check("stall_valid_lag", {31'd0, pl_valid}, 32'd0);
    idle(1);
    check("stall_ok_single", {31'd0, frame_ok}, 32'd0);
    check("stall_first", {23'd0, pl_valid, pl_data}, {23'd0, 1'b1, 8'hA1});
    repeat (5) begin
      idle(1);
      check("stall_hold0", {22'd0, pl_valid, pl_last, pl_data}, {22'd0, 1'b1, 1'b0, 8'hA1});
    end
    send_byte(8'h33);
    pl_ready = 1'b1;
    idle(1);
    pl_ready = 1'b0;
    repeat (5) begin
      idle(1);
      check("stall_hold1", {22'd0, pl_valid, pl_last, pl_data}, {22'd0, 1'b1, 1'b0, 8'hB2});
    end
    pl_ready = 1'b1;
    idle(10);
    check_stream("stall", 4, 64'hA1B2C3D4);
    check("stall_ok_count", mon_ok, 1);
    check("stall_ovr_count", mon_err, 1);
    check("stall_ovr_code", {30'd0, mon_code}, 32'd2);
    check("stall_end_valid", {31'd0, pl_valid}, 32'd0);

    // ---- overrun on the same cycle as the last handshake ----
    mon_clear();
    pl_ready = 1'b0;
    send_bytes(5, 64'h55AA017F80);
    wait_for_valid(5, "ovrlast_valid_wait");
    pl_ready = 1'b1;
    rx_done  = 1'b1;
    rx_data  = 8'h99;
    idle(1);
    rx_done  = 1'b0;
    pl_ready = 1'b0;
    check("ovrlast_valid_drop", {31'd0, pl_valid}, 32'd0);
    check("ovrlast_err", {29'd0, frame_err, err_code}, {29'd0, 1'b1, 2'd2});
    idle(3);
    check_stream("ovrlast", 1, 64'h7F);
    check("ovrlast_ok_count", mon_ok, 1);

    // ---- reset during drain ----
    mon_clear();
    pl_ready = 1'b0;
    send_bytes(6, 64'h55AA02102032);
    wait_for_valid(5, "rstdrain_valid_wait");
    #2;
    rst = 1'b1;
    #1;
    check("rstdrain_outputs", {22'd0, pl_valid, pl_last, pl_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    check("rstdrain_no_err", mon_err, 0);
    mon_clear();
    pl_ready = 1'b1;
    send_bytes(5, 64'h55AA017F80);
    idle(10);
    check_stream("rstdrain_recover", 1, 64'h7F);

    // ---- long gap inside a frame ----
    mon_clear();
    send_bytes(4, 64'h55AA0401);
`ifdef UART_FRAME_TIMEOUT_EN
    idle(TMO - 5);
    check("tmo_not_early", mon_err, 0);
    idle(10);
    check("tmo_err_count", mon_err, 1);
    check("tmo_err_code", {30'd0, mon_code}, 32'd3);
    mon_clear();
    send_bytes(5, 64'h55AA017F80);
    idle(10);
    check("tmo_recover_ok", mon_ok, 1);
    check_stream("tmo_recover", 1, 64'h7F);
`else
    idle(300);
    check("gap_no_err", mon_err, 0);
    send_bytes(4, 64'h0203040E);
    idle(10);
    check("gap_ok_count", mon_ok, 1);
    check_stream("gap", 4, 64'h01020304);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
